// File: rtl/rst_ctrl.sv
// Reset request controller: holds every domain reset low for pHOLD cycles, then releases them in order pGAP cycles apart.
// Define RST_CTRL_CNT_EN to add the rst_cnt port, a saturating count of accepted reset requests.
`timescale 1ns/1ps
module rst_ctrl #(
  parameter int pHOLD    = 16,
  parameter int pGAP     = 4,
  parameter int pDOMAINS = 3
) (
  input  logic                clk,
  input  logic                rst_async,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_cause,
  output logic [pDOMAINS-1:0] rst_out_n,
  output logic                rst_done,
`ifdef RST_CTRL_CNT_EN
  output logic [7:0]          rst_cnt,
`endif
  output logic [1:0]          rst_cause
);

  localparam int HW = $clog2(pHOLD + 1);
  localparam int GW = $clog2(pGAP + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(pHOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(pGAP - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [pDOMAINS-1:0] out_q, out_d, out_next_rel;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [1:0]          cause_q, cause_d;
  logic                accept;
  logic                all_rel;

  // Cause 01 is reserved for power-on; it and 00 are recorded as a generic request.
  function automatic logic [1:0] map_cause(input logic [1:0] c);
    return c[1] ? c : 2'b11;
  endfunction

  assign accept       = req_valid & ready_q;
  assign all_rel      = &out_q;
  // Thermometer step: sets the lowest still-asserted domain (000->001->011->111).
  assign out_next_rel = out_q | (out_q + 1'b1);

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= 2'b01;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASSERT:  if (hold_q == HOLD_LAST) state_d = RELEASE;
      RELEASE: if (all_rel) state_d = IDLE;
      IDLE:    if (accept) state_d = ASSERT;
      default: state_d = ASSERT;
    endcase
  end

  always_comb begin
    hold_d  = hold_q;
    gap_d   = gap_q;
    out_d   = out_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    cause_d = cause_q;
    case (state_q)
      ASSERT: begin
        out_d = '0;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          gap_d  = '0;
          out_d  = out_next_rel;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        if (all_rel) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          gap_d = '0;
          out_d = out_next_rel;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          out_d   = '0;
          hold_d  = '0;
          cause_d = map_cause(req_cause);
        end
      end
      default: out_d = '0;
    endcase
  end

  assign req_ready = ready_q;
  assign rst_out_n = out_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

`ifdef RST_CTRL_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      cnt_q <= '0;
    end else if (accept && state_q == IDLE && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign rst_cnt = cnt_q;
`endif

endmodule
